// File: rtl/bullcow_pkg.sv
// Shared types and default parameters for the Bulls and Cows match engine.
package bullcow_pkg;

    localparam int DEF_N_DIGITS = 4;
    localparam int DEF_DIGIT_W  = 4;
    localparam int DEF_SCORE_W  = 8;

    typedef enum logic [2:0] {
        J1_SETUP = 3'b000,
        J2_SETUP = 3'b001,
        J1_GUESS = 3'b010,
        J2_GUESS = 3'b011,
        END_GAME = 3'b111
    } state_t;

endpackage

// File: rtl/bullcow_score.sv
// Combinational scorer: checks that a guess is legal (digits 0..9, all distinct)
// and counts its bulls and cows against a secret.
module bullcow_score
    import bullcow_pkg::*;
#(
    parameter int N_DIGITS = DEF_N_DIGITS,
    parameter int DIGIT_W  = DEF_DIGIT_W,
    parameter int CNT_W    = $clog2(DEF_N_DIGITS + 1)
) (
    input  logic [N_DIGITS*DIGIT_W-1:0] guess,
    input  logic [N_DIGITS*DIGIT_W-1:0] secret,
    output logic                        valid,
    output logic [CNT_W-1:0]            bulls,
    output logic [CNT_W-1:0]            cows
);

    logic [N_DIGITS-1:0] digit_ok;
    logic [N_DIGITS-1:0] dup_vec;
    logic [N_DIGITS-1:0] bull_vec;
    logic [N_DIGITS-1:0] cow_vec;

    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            logic [DIGIT_W-1:0] g_dig;
            logic [DIGIT_W-1:0] s_dig;
            logic               cow_hit;
            logic               dup_hit;

            assign g_dig = guess[gi*DIGIT_W +: DIGIT_W];
            assign s_dig = secret[gi*DIGIT_W +: DIGIT_W];
            assign digit_ok[gi] = (g_dig <= DIGIT_W'(9));
            assign bull_vec[gi] = (g_dig == s_dig);

            // cow_hit: digit appears elsewhere in the secret; dup_hit: repeats later in the guess
            always_comb begin
                cow_hit = 1'b0;
                dup_hit = 1'b0;
                for (int j = 0; j < N_DIGITS; j++) begin
                    if (j != gi && secret[j*DIGIT_W +: DIGIT_W] == g_dig)
                        cow_hit = 1'b1;
                    if (j > gi && guess[j*DIGIT_W +: DIGIT_W] == g_dig)
                        dup_hit = 1'b1;
                end
            end

            assign cow_vec[gi] = cow_hit & ~bull_vec[gi];
            assign dup_vec[gi] = dup_hit;
        end
    endgenerate

    assign valid = (&digit_ok) & ~(|dup_vec);

    always_comb begin
        bulls = '0;
        cows  = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            bulls = bulls + CNT_W'(bull_vec[i]);
            cows  = cows + CNT_W'(cow_vec[i]);
        end
    end

endmodule

// File: rtl/bullcow_match.sv
// Two-player Bulls and Cows referee: secret setup, alternating guesses, win counters.
// Define BULLCOW_SCORE_SAT_EN to make win counters saturate instead of wrapping.
module bullcow_match
    import bullcow_pkg::*;
#(
    parameter int N_DIGITS = DEF_N_DIGITS,
    parameter int DIGIT_W  = DEF_DIGIT_W,
    parameter int SCORE_W  = DEF_SCORE_W
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             enter,
    input  logic [N_DIGITS*DIGIT_W-1:0]      digits,
    output logic [2:0]                       state,
    output logic [$clog2(N_DIGITS+1)-1:0]    bulls,
    output logic [$clog2(N_DIGITS+1)-1:0]    cows,
    output logic                             result_valid,
    output logic                             error,
    output logic [SCORE_W-1:0]               points_j1,
    output logic [SCORE_W-1:0]               points_j2
);

    localparam int CNT_W = $clog2(N_DIGITS + 1);
    localparam int VAL_W = N_DIGITS * DIGIT_W;

    state_t             state_q, state_d;
    logic [VAL_W-1:0]   secret1_q, secret1_d;
    logic [VAL_W-1:0]   secret2_q, secret2_d;
    logic [CNT_W-1:0]   bulls_q, bulls_d;
    logic [CNT_W-1:0]   cows_q, cows_d;
    logic               result_valid_q, result_valid_d;
    logic               error_q, error_d;
    logic [SCORE_W-1:0] points_j1_q, points_j1_d;
    logic [SCORE_W-1:0] points_j2_q, points_j2_d;

    logic [VAL_W-1:0]   score_secret;
    logic               sc_valid;
    logic [CNT_W-1:0]   sc_bulls;
    logic [CNT_W-1:0]   sc_cows;

    function automatic logic [SCORE_W-1:0] bump(input logic [SCORE_W-1:0] p);
`ifdef BULLCOW_SCORE_SAT_EN
        return (&p) ? p : p + SCORE_W'(1);
`else
        return p + SCORE_W'(1);
`endif
    endfunction

    // The same scorer validates setup entries; its bull/cow outputs are ignored there.
    assign score_secret = (state_q == J2_GUESS) ? secret1_q : secret2_q;

    bullcow_score #(
        .N_DIGITS (N_DIGITS),
        .DIGIT_W  (DIGIT_W),
        .CNT_W    (CNT_W)
    ) u_score (
        .guess  (digits),
        .secret (score_secret),
        .valid  (sc_valid),
        .bulls  (sc_bulls),
        .cows   (sc_cows)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= J1_SETUP;
            secret1_q      <= '0;
            secret2_q      <= '0;
            bulls_q        <= '0;
            cows_q         <= '0;
            result_valid_q <= 1'b0;
            error_q        <= 1'b0;
            points_j1_q    <= '0;
            points_j2_q    <= '0;
        end else begin
            state_q        <= state_d;
            secret1_q      <= secret1_d;
            secret2_q      <= secret2_d;
            bulls_q        <= bulls_d;
            cows_q         <= cows_d;
            result_valid_q <= result_valid_d;
            error_q        <= error_d;
            points_j1_q    <= points_j1_d;
            points_j2_q    <= points_j2_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        secret1_d      = secret1_q;
        secret2_d      = secret2_q;
        bulls_d        = bulls_q;
        cows_d         = cows_q;
        result_valid_d = 1'b0;
        error_d        = 1'b0;
        points_j1_d    = points_j1_q;
        points_j2_d    = points_j2_q;

        if (enter) begin
            case (state_q)
                J1_SETUP: begin
                    if (sc_valid) begin
                        secret1_d = digits;
                        state_d   = J2_SETUP;
                    end else begin
                        error_d = 1'b1;
                    end
                end
                J2_SETUP: begin
                    if (sc_valid) begin
                        secret2_d = digits;
                        state_d   = J1_GUESS;
                    end else begin
                        error_d = 1'b1;
                    end
                end
                J1_GUESS, J2_GUESS: begin
                    if (!sc_valid) begin
                        error_d = 1'b1;
                    end else begin
                        bulls_d        = sc_bulls;
                        cows_d         = sc_cows;
                        result_valid_d = 1'b1;
                        if (sc_bulls == CNT_W'(N_DIGITS)) begin
                            state_d = END_GAME;
                            if (state_q == J1_GUESS)
                                points_j1_d = bump(points_j1_q);
                            else
                                points_j2_d = bump(points_j2_q);
                        end else begin
                            state_d = (state_q == J1_GUESS) ? J2_GUESS : J1_GUESS;
                        end
                    end
                end
                END_GAME: begin
                    secret1_d = '0;
                    secret2_d = '0;
                    state_d   = J1_SETUP;
                end
                default: state_d = J1_SETUP;
            endcase
        end
    end

    assign state        = state_q;
    assign bulls        = bulls_q;
    assign cows         = cows_q;
    assign result_valid = result_valid_q;
    assign error        = error_q;
    assign points_j1    = points_j1_q;
    assign points_j2    = points_j2_q;

endmodule

// File: tb/tb_bullcow_match.sv
// Bench for bullcow_match: directed games plus random play against a digit-level game model.
module tb_bullcow_match;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int SW = 2;
    localparam int CW = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enter = 1'b0;
    logic [15:0]   digits = '0;
    logic [2:0]    state;
    logic [CW-1:0] bulls;
    logic [CW-1:0] cows;
    logic          result_valid;
    logic          error;
    logic [SW-1:0] points_j1;
    logic [SW-1:0] points_j2;

    bullcow_match #(.N_DIGITS(N), .DIGIT_W(W), .SCORE_W(SW)) dut (
        .clock        (clock),
        .reset        (reset),
        .enter        (enter),
        .digits       (digits),
        .state        (state),
        .bulls        (bulls),
        .cows         (cows),
        .result_valid (result_valid),
        .error        (error),
        .points_j1    (points_j1),
        .points_j2    (points_j2)
    );

    always #5 clock = ~clock;

    int passed = 0;
    int total  = 0;

    // Game model: states by their published codes, secrets as digit strings.
    int          m_state, m_b, m_c, m_rv, m_err, m_p1, m_p2;
    logic [15:0] m_s1, m_s2;

    function automatic int dig(input logic [15:0] v, input int i);
        return int'((v >> (4 * i)) & 16'hF);
    endfunction

    function automatic bit is_valid(input logic [15:0] v);
        for (int i = 0; i < N; i++) begin
            if (dig(v, i) > 9) return 1'b0;
            for (int j = 0; j < i; j++)
                if (dig(v, i) == dig(v, j)) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void score(input logic [15:0] g, input logic [15:0] s,
                                  output int b, output int c);
        b = 0;
        c = 0;
        for (int i = 0; i < N; i++) begin
            if (dig(g, i) == dig(s, i)) b++;
            else
                for (int j = 0; j < N; j++)
                    if (j != i && dig(s, j) == dig(g, i)) begin
                        c++;
                        break;
                    end
        end
    endfunction

    function automatic int win(input int p);
`ifdef BULLCOW_SCORE_SAT_EN
        return (p == 3) ? 3 : p + 1;
`else
        return (p + 1) % 4;
`endif
    endfunction

    function automatic logic [15:0] rand_valid();
        int          a[10];
        int          k, t;
        logic [15:0] v;
        for (int i = 0; i < 10; i++) a[i] = i;
        for (int i = 9; i > 0; i--) begin
            k = int'($urandom_range(i, 0));
            t = a[i]; a[i] = a[k]; a[k] = t;
        end
        v = '0;
        for (int i = 0; i < N; i++) v = v | (16'(a[i]) << (4 * i));
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_step(input bit rst, input bit en, input logic [15:0] v);
        int b, c;
        m_rv  = 0;
        m_err = 0;
        if (rst) begin
            m_state = 0; m_s1 = '0; m_s2 = '0;
            m_b = 0; m_c = 0; m_p1 = 0; m_p2 = 0;
        end else if (en) begin
            if (m_state == 7) begin
                m_s1 = '0; m_s2 = '0; m_state = 0;
            end else if (!is_valid(v)) begin
                m_err = 1;
            end else if (m_state == 0) begin
                m_s1 = v; m_state = 1;
            end else if (m_state == 1) begin
                m_s2 = v; m_state = 2;
            end else begin
                score(v, (m_state == 2) ? m_s2 : m_s1, b, c);
                m_b = b; m_c = c; m_rv = 1;
                if (b == N) begin
                    if (m_state == 2) m_p1 = win(m_p1);
                    else m_p2 = win(m_p2);
                    m_state = 7;
                end else begin
                    m_state = (m_state == 2) ? 3 : 2;
                end
            end
        end
    endtask

    task automatic cycle(input bit rst, input bit en, input logic [15:0] v);
        @(negedge clock);
        reset  = rst;
        enter  = en;
        digits = v;
        @(posedge clock);
        #1;
        model_step(rst, en, v);
        check("state", 32'(state), 32'(m_state));
        check("bulls", 32'(bulls), 32'(m_b));
        check("cows", 32'(cows), 32'(m_c));
        check("result_valid", 32'(result_valid), 32'(m_rv));
        check("error", 32'(error), 32'(m_err));
        check("points_j1", 32'(points_j1), 32'(m_p1));
        check("points_j2", 32'(points_j2), 32'(m_p2));
        if (en || rst)
            $display("txn rst=%0d en=%0d digits=%h state=%0d bulls=%0d cows=%0d rv=%0d err=%0d p1=%0d p2=%0d",
                     rst, en, v, state, bulls, cows, result_valid, error, points_j1, points_j2);
    endtask

    initial begin
        int r;
        logic [15:0] v;

        // Reset state
        cycle(1, 0, 16'h0000);
        cycle(1, 1, 16'h1234);
        cycle(0, 0, 16'h0000);

        // Invalid setup entries then valid setup
        cycle(0, 1, 16'h1123);
        cycle(0, 1, 16'h12A4);
        cycle(0, 0, 16'h0000);
        check("setup_stays_j1", 32'(state), 32'd0);
        cycle(0, 1, 16'h1234);
        cycle(0, 1, 16'h5678);
        check("setup_done", 32'(state), 32'd2);

        // Partial score, then J2 wins, then back to setup
        cycle(0, 1, 16'h5687);
        check("partial_bulls", 32'(bulls), 32'd2);
        check("partial_cows", 32'(cows), 32'd2);
        cycle(0, 0, 16'h0000);
        cycle(0, 1, 16'h1234);
        check("win_p2", 32'(points_j2), 32'd1);
        check("win_state", 32'(state), 32'd7);
        cycle(0, 1, 16'hFFFF);
        cycle(0, 0, 16'h0000);

        // Four J1 wins with enter held high across the whole sequence
        for (int g = 0; g < 4; g++) begin
            cycle(0, 1, 16'h1234);
            cycle(0, 1, 16'h5678);
            cycle(0, 1, 16'h5678);
            cycle(0, 1, 16'h0000);
        end
`ifdef BULLCOW_SCORE_SAT_EN
        check("overflow_p1", 32'(points_j1), 32'd3);
`else
        check("overflow_p1", 32'(points_j1), 32'd0);
`endif

        // Random play
        for (int t = 0; t < 400; t++) begin
            r = int'($urandom_range(99, 0));
            if (r < 2) begin
                cycle(1, 1, rand_valid());
            end else if (r < 25) begin
                cycle(0, 0, 16'(($urandom)));
            end else begin
                r = int'($urandom_range(9, 0));
                if (r < 2) v = 16'($urandom);
                else if (r < 4 && m_state == 2) v = m_s2;
                else if (r < 4 && m_state == 3) v = m_s1;
                else v = rand_valid();
                cycle(0, 1, v);
            end
        end

        // Reset colliding with enter in J1_GUESS
        cycle(1, 0, 16'h0000);
        cycle(0, 1, 16'h1234);
        cycle(0, 1, 16'h5678);
        cycle(0, 1, 16'h9012);
        cycle(0, 1, 16'h9012);
        check("pre_collision_state", 32'(state), 32'd2);
        cycle(1, 1, 16'h5678);
        check("collision_state", 32'(state), 32'd0);
        check("collision_bulls", 32'(bulls), 32'd0);
        cycle(0, 0, 16'h0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bullcow_match.md
BULLCOW_MATCH -- requirements
Module: bullcow_match

Interface
REQ-001 Parameter N_DIGITS, default 4: digits per secret or guess; legal range 2..10.
REQ-002 Parameter DIGIT_W, default 4: bits per digit; minimum 4.
REQ-003 Parameter SCORE_W, default 8: bits per player win counter.
REQ-004 Port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port enter, input, 1 bit: one-cycle strobe that submits the value on digits.
REQ-007 Port digits, input, N_DIGITS*DIGIT_W bits: digit i occupies bits [i*DIGIT_W +: DIGIT_W]; digit 0 is rightmost.
REQ-008 Port state, output, 3 bits: current FSM state (encoding per REQ-040).
REQ-009 Port bulls, output, $clog2(N_DIGITS+1) bits: bulls of the last valid guess.
REQ-010 Port cows, output, $clog2(N_DIGITS+1) bits: cows of the last valid guess.
REQ-011 Port result_valid, output, 1 bit: one-cycle pulse when bulls and cows update.
REQ-012 Port error, output, 1 bit: one-cycle pulse when a submitted value is invalid.
REQ-013 Port points_j1, output, SCORE_W bits: player 1 win count.
REQ-014 Port points_j2, output, SCORE_W bits: player 2 win count.

Function
REQ-015 A value SHALL be valid only if every digit is at most 9 and all digits are pairwise distinct.
REQ-016 bulls SHALL equal the count of positions i where guess[i] equals secret[i].
REQ-017 cows SHALL equal the count of positions i where guess[i] differs from secret[i] but equals secret[j] for some j != i.
REQ-018 FSM states SHALL be J1_SETUP, J2_SETUP, J1_GUESS, J2_GUESS and END_GAME.
REQ-019 J1_SETUP: a valid enter SHALL store secret1 and go to J2_SETUP; an invalid enter SHALL pulse error and stay in J1_SETUP.
REQ-020 J2_SETUP: a valid enter SHALL store secret2 and go to J1_GUESS; an invalid enter SHALL pulse error and stay in J2_SETUP.
REQ-021 J1_GUESS: player 1 guesses secret2.
REQ-022 J2_GUESS: player 2 guesses secret1.
REQ-023 In either guess state, an invalid enter SHALL pulse error and leave the state unchanged.
REQ-024 In either guess state, a valid enter SHALL register bulls and cows and pulse result_valid in the next cycle.
REQ-025 After a valid guess, bulls equal to N_DIGITS SHALL move the FSM to END_GAME and increment the guesser's counter; otherwise the FSM SHALL pass the turn to the other guess state.
REQ-026 END_GAME: enter SHALL clear both secrets and return the FSM to J1_SETUP; validity is not checked in END_GAME.
REQ-027 All outputs SHALL be registered; every response appears in the cycle after the enter cycle.
REQ-028 enter held high SHALL count as one submission per cycle.
REQ-029 bulls and cows SHALL hold their values until the next valid guess.
REQ-030 Points SHALL persist across games and SHALL be cleared only by reset.

Reset
REQ-031 Reset SHALL take priority over a simultaneous enter.
REQ-032 On reset: state = J1_SETUP; secrets, bulls, cows, points_j1 and points_j2 = 0; result_valid and error = 0.
REQ-033 Reset asserted mid-game SHALL abandon the game and award no point.

Configuration
REQ-034 Macro BULLCOW_SCORE_SAT_EN SHALL select the counter overflow behaviour.
REQ-035 With BULLCOW_SCORE_SAT_EN defined, a win counter at 2^SCORE_W-1 SHALL hold that value.
REQ-036 Without BULLCOW_SCORE_SAT_EN, a win counter at 2^SCORE_W-1 SHALL wrap to 0.

Structure
REQ-037 Package bullcow_pkg SHALL contain state_t and the default parameter constants.
REQ-038 Combinational sub-module bullcow_score SHALL compute valid, bulls and cows from a guess and a secret.
REQ-039 One bullcow_score instance SHALL be shared by setup validation and guessing.
REQ-040 state_t encoding: J1_SETUP=000, J2_SETUP=001, J1_GUESS=010, J2_GUESS=011, END_GAME=111.

Verification
REQ-041 Valid setup: enter 1234, then 5678 -> state goes J2_SETUP, then J1_GUESS; error stays 0.
REQ-042 Invalid setup: enter 1123, then 12A4 in J1_SETUP -> error pulses each time; state stays J1_SETUP.
REQ-043 Partial score: secrets 1234 / 5678; J1 guesses 5687 -> bulls=2, cows=2, result_valid pulses once; state goes J2_GUESS.
REQ-044 Win: J2 guesses 1234 -> bulls=4, state END_GAME, points_j2=1; enter -> state J1_SETUP, points unchanged.
REQ-045 Overflow: SCORE_W=2, four J1 wins -> points_j1 = 3 with BULLCOW_SCORE_SAT_EN, 0 without.
REQ-046 Reset collision: reset and enter asserted together in J1_GUESS -> state J1_SETUP, all outputs 0.
